// File: rtl/pb_debouncer_pkg.sv
// Shared constants and channel-state type for the push-button/switch debouncer.
package pb_debouncer_pkg;

  localparam int TICKDIV_DEF      = 50000;
  localparam int STABLE_TICKS_DEF = 8;

  typedef enum logic {
    CH_STABLE  = 1'b0,
    CH_PENDING = 1'b1
  } chan_state_e;

  // Counter must hold STABLE_TICKS-1 with one bit of headroom.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks) + 1;
  endfunction

endpackage

// File: rtl/pb_debouncer_if.sv
// Raw-input / debounced-output bundle between the board pins, the debouncer and the I/O block.
interface pb_debouncer_if #(
  parameter int WIDTH = 20
);
  logic [WIDTH-1:0] iRaw;
  logic [WIDTH-1:0] iClear;
  logic [WIDTH-1:0] oLevel;
  logic [WIDTH-1:0] oRise;
  logic [WIDTH-1:0] oFall;
  logic [WIDTH-1:0] oEvent;

  modport master (
    output iRaw, iClear,
    input  oLevel, oRise, oFall, oEvent
  );

  modport slave (
    input  iRaw, iClear,
    output oLevel, oRise, oFall, oEvent
  );
endinterface

// File: rtl/pb_debounce_chan.sv
// One channel: 2-flop synchroniser, tick-driven stability counter, level flop, edge pulses.
// Level accepts a change on the STABLE_TICKS-th tick of an unbroken mismatch; edges pulse one clock later.
module pb_debounce_chan
  import pb_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int INVERT       = 0
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iRaw,
  input  logic iTick,
  output logic oLevel,
  output logic oRise,
  output logic oFall
);

  localparam int CW = cnt_width(STABLE_TICKS);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  chan_state_e   state;

  always_comb begin
    sync1_d     = iRaw ^ (INVERT != 0);
    sync2_d     = sync1_q;
    state       = (sync2_q != level_q) ? CH_PENDING : CH_STABLE;
    cnt_d       = cnt_q;
    level_d     = level_q;
    case (state)
      CH_STABLE: cnt_d = '0;
      CH_PENDING: begin
        if (iTick) begin
          if (cnt_q == CW'(STABLE_TICKS - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: cnt_d = '0;
    endcase
    // Edges are taken from the registered level so the pulse trails the level edge by a clock.
    level_dly_d = level_q;
    rise_d      = level_q & ~level_dly_q;
    fall_d      = ~level_q & level_dly_q;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oLevel = level_q;
  assign oRise  = rise_q;
  assign oFall  = fall_q;

endmodule

// File: rtl/pb_debouncer.sv
// Debouncer bank: shared prescaler tick feeding WIDTH independent channels; clean levels and edge pulses.
// Optional sticky press flags under PB_DEBOUNCE_STICKY_EN (set on rise, clear on iClear, set wins).
module pb_debouncer
  import pb_debouncer_pkg::*;
#(
  parameter int WIDTH        = 20,
  parameter int TICKDIV      = TICKDIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int INVERT       = 0
) (
  input  logic           iClk,
  input  logic           iReset,
  pb_debouncer_if.slave  bus
);

  localparam int PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

  logic [PW-1:0]    p_q, p_d;
  logic             tick;
  logic [WIDTH-1:0] level, rise, fall;

  always_comb begin
    tick = (p_q == PW'(TICKDIV - 1));
    p_d  = tick ? '0 : p_q + PW'(1);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pb_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .INVERT       (INVERT)
    ) u_chan (
      .iClk   (iClk),
      .iReset (iReset),
      .iRaw   (bus.iRaw[i]),
      .iTick  (tick),
      .oLevel (level[i]),
      .oRise  (rise[i]),
      .oFall  (fall[i])
    );
  end

  assign bus.oLevel = level;
  assign bus.oRise  = rise;
  assign bus.oFall  = fall;

`ifdef PB_DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] evt_q, evt_d;

  always_comb begin
    evt_d = rise | (evt_q & ~bus.iClear);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.oEvent = evt_q;
`else
  logic [WIDTH-1:0] unused_clear;
  assign unused_clear = bus.iClear;
  assign bus.oEvent   = '0;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Bench for pb_debouncer: directed scenarios plus randomized traffic against a tick-counting reference model.
`timescale 1ns/1ps
module tb_pb_debouncer;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pb_debouncer_if #(.WIDTH(W)) bus();

  pb_debouncer #(
    .WIDTH        (W),
    .TICKDIV      (TD),
    .STABLE_TICKS (ST),
    .INVERT       (0)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: s is the raw input two edges old; a channel counts the ticks seen
  // during an unbroken mismatch and takes the new value on the ST-th; pulses trail by one clock.
  logic [W-1:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_evt = '0;
  logic [W-1:0] m_pr = '0, m_pf = '0;
  logic [W-1:0] m_hist[$];
  int           m_ticks[W];
  int           m_cyc = 0;

  always @(posedge clk) begin : model
    logic [W-1:0] s;
    bit           tk;
    if (rst) begin
      m_lvl = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_pr = '0; m_pf = '0;
      m_hist = {};
      m_cyc = 0;
      for (int c = 0; c < W; c++) m_ticks[c] = 0;
    end else begin
      s  = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : '0;
      tk = (m_cyc % TD) == (TD - 1);
`ifdef PB_DEBOUNCE_STICKY_EN
      m_evt = m_rise | (m_evt & ~bus.iClear);
`endif
      m_rise = m_pr; m_fall = m_pf; m_pr = '0; m_pf = '0;
      for (int c = 0; c < W; c++) begin
        if (s[c] != m_lvl[c]) begin
          if (tk) m_ticks[c]++;
          if (m_ticks[c] == ST) begin
            m_lvl[c] = s[c];
            m_ticks[c] = 0;
            if (s[c]) m_pr[c] = 1'b1; else m_pf[c] = 1'b1;
          end
        end else begin
          m_ticks[c] = 0;
        end
      end
      if (m_hist.size() >= 2) void'(m_hist.pop_front());
      m_hist.push_back(bus.iRaw);
      m_cyc++;
    end
  end

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    int lvl_at = -1;
    int rise_cnt = 0;
    rst = 1'b1; bus.iRaw = 4'hF; bus.iClear = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc %0d: got %h want 0000", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL reset_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      if (bus.oLevel === 4'hF && lvl_at < 0) lvl_at = k;
      if (bus.oRise !== 4'h0) begin
        rise_cnt++;
        n_checks++;
        if (bus.oRise !== 4'hF) begin
          n_errors++;
          $display("FAIL reset_rise_value: got %h want f", bus.oRise);
        end
      end
    end
    n_checks++;
    if (lvl_at < 1 || lvl_at > 14) begin
      n_errors++;
      $display("FAIL reset_accept_latency: got %0d want 1..14", lvl_at);
    end
    n_checks++;
    if (rise_cnt != 1) begin
      n_errors++;
      $display("FAIL reset_rise_count: got %0d want 1", rise_cnt);
    end
  endtask

  task automatic test_glitch();
    logic seen_lvl = 1'b0;
    logic seen_rise = 1'b0;
    bus.iRaw = '0;
    settle(20);
    n_checks++;
    if (bus.oLevel !== 4'h0) begin
      n_errors++;
      $display("FAIL glitch_precond: got %h want 0", bus.oLevel);
    end
    for (int k = 0; k < 25; k++) begin
      bus.iRaw[0] = (k < 5);
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL glitch_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      seen_lvl  |= bus.oLevel[0];
      seen_rise |= bus.oRise[0];
    end
    n_checks++;
    if ({seen_lvl, seen_rise} !== 2'b00) begin
      n_errors++;
      $display("FAIL glitch_reject: level/rise seen %b want 00", {seen_lvl, seen_rise});
    end
  endtask

  task automatic test_press();
    int up_at = -1, dn_at = -1, rise_at = -1;
    int rises = 0, falls = 0;
    bus.iRaw = 4'b0010;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL press_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      if (bus.oLevel[1] === 1'b1 && up_at < 0) up_at = k;
      if (bus.oLevel[1] === 1'b0 && up_at > 0 && dn_at < 0) dn_at = k;
      if (bus.oRise[1] === 1'b1) begin rises++; rise_at = k; end
      if (bus.oFall[1] === 1'b1) falls++;
      if (k == 30) bus.iRaw = 4'b0000;
    end
    n_checks++;
    if (up_at < 11 || up_at > 14) begin
      n_errors++;
      $display("FAIL press_rise_latency: got %0d want 11..14", up_at);
    end
    n_checks++;
    if (dn_at - 30 < 11 || dn_at - 30 > 14) begin
      n_errors++;
      $display("FAIL press_fall_latency: got %0d want 11..14", dn_at - 30);
    end
    n_checks++;
    if (rises != 1 || falls != 1) begin
      n_errors++;
      $display("FAIL press_pulse_count: got rise %0d fall %0d want 1 1", rises, falls);
    end
    n_checks++;
    if (rise_at != up_at + 1) begin
      n_errors++;
      $display("FAIL press_rise_timing: got %0d want %0d", rise_at, up_at + 1);
    end
  endtask

  task automatic test_bounce();
    int   changes = 0, chg_k = -1;
    logic prev;
    prev = bus.oLevel[2];
    for (int k = 0; k < 54; k++) begin
      bus.iRaw[2] = (k < 24) ? (((k / 3) % 2) == 0) : 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL bounce_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      if (bus.oLevel[2] !== prev) begin changes++; chg_k = k; end
      prev = bus.oLevel[2];
    end
    n_checks++;
    if (changes != 1 || prev !== 1'b1) begin
      n_errors++;
      $display("FAIL bounce_changes: got %0d changes final %b want 1 change final 1", changes, prev);
    end
    n_checks++;
    if (chg_k < 34) begin
      n_errors++;
      $display("FAIL bounce_accept_after_hold: got k=%0d want >=34", chg_k);
    end
  endtask

  task automatic test_simul();
    int k1 = -1, k3 = -1, pulses = 0;
    bus.iRaw = '0;
    settle(20);
    bus.iRaw = 4'b1010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL simul_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      if (bus.oLevel[1] === 1'b1 && k1 < 0) k1 = k;
      if (bus.oLevel[3] === 1'b1 && k3 < 0) k3 = k;
      if (bus.oRise !== 4'b0000) begin
        pulses++;
        n_checks++;
        if (bus.oRise !== 4'b1010) begin
          n_errors++;
          $display("FAIL simul_rise_value: got %b want 1010", bus.oRise);
        end
      end
    end
    n_checks++;
    if (k1 < 0 || k1 != k3) begin
      n_errors++;
      $display("FAIL simul_same_cycle: got ch1 %0d ch3 %0d want equal", k1, k3);
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL simul_single_pulse: got %0d want 1", pulses);
    end
  endtask

`ifdef PB_DEBOUNCE_STICKY_EN
  task automatic test_sticky();
    int seen;
    bus.iRaw = '0;
    settle(20);
    bus.iClear = 4'hF;
    @(negedge clk);
    bus.iClear = '0;
    @(negedge clk);
    n_checks++;
    if (bus.oEvent !== 4'h0) begin
      n_errors++;
      $display("FAIL sticky_cleared: got %h want 0", bus.oEvent);
    end
    // Plain press: flag sets after the rise pulse and holds until cleared.
    bus.iRaw = 4'b0001;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.oRise[0] === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen == 0) begin
      n_errors++;
      $display("FAIL sticky_rise_timeout: got no rise want rise within 20");
    end
    settle(4);
    n_checks++;
    if (bus.oEvent !== 4'b0001) begin
      n_errors++;
      $display("FAIL sticky_set_hold: got %b want 0001", bus.oEvent);
    end
    bus.iClear = 4'b0001;
    @(negedge clk);
    bus.iClear = '0;
    n_checks++;
    if (bus.oEvent !== 4'b0000) begin
      n_errors++;
      $display("FAIL sticky_clear: got %b want 0000", bus.oEvent);
    end
    // Clear coinciding with the rise pulse loses to the set.
    bus.iRaw = '0;
    settle(20);
    bus.iRaw = 4'b0001;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.oRise[0] === 1'b1) seen = 1;
    end
    bus.iClear = 4'b0001;
    @(negedge clk);
    bus.iClear = '0;
    n_checks++;
    if (seen == 0 || bus.oEvent[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sticky_set_wins: got seen %0d event %b want 1 1", seen, bus.oEvent[0]);
    end
  endtask
`else
  task automatic test_sticky();
    bus.iClear = 4'hF;
    bus.iRaw = 4'h0;
    settle(20);
    bus.iRaw = 4'hF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.oEvent !== 4'h0) begin
        n_errors++;
        $display("FAIL sticky_disabled: got %h want 0", bus.oEvent);
      end
    end
    bus.iClear = '0;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) bus.iRaw[$urandom_range(0, W-1)] ^= 1'b1;
      bus.iClear = W'($urandom_range(0, 15) & $urandom_range(0, 15));
      rst = (k >= 200 && k < 202);
      @(negedge clk);
      n_checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oEvent} !== {m_lvl, m_rise, m_fall, m_evt}) begin
        n_errors++;
        $display("FAIL random_model k=%0d: got %h want %h", k,
                 {bus.oLevel, bus.oRise, bus.oFall, bus.oEvent}, {m_lvl, m_rise, m_fall, m_evt});
      end
      if ((bus.oRise & bus.oFall) !== 4'h0) begin
        n_errors++;
        $display("FAIL random_rise_and_fall k=%0d: got %b want 0000", k, bus.oRise & bus.oFall);
      end
    end
    rst = 1'b0;
    bus.iClear = '0;
  endtask

  initial begin
    bus.iRaw   = '0;
    bus.iClear = '0;
    test_reset();
    test_glitch();
    test_press();
    test_bounce();
    test_simul();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
